// File: rtl/div_result_buf.sv
// Result-capture FIFO behind the sequential divider. It turns each completion or overflow
// edge into a saturated, flagged entry and streams the entries out over valid/ready.
module div_result_buf #(
  parameter int WIDTH = 32,
  parameter int FBITS = 29,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       div_done,
  input  logic                       div_valid,
  input  logic                       div_dbz,
  input  logic                       div_ovf,
  input  logic [WIDTH-1:0]           div_val,
  input  logic                       q_neg,
  output logic                       hold,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_dbz,
  output logic                       m_ovf,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  // The fraction position only matters to the consumer; the buffer never scales values.
  localparam int unused_fbits = FBITS;

  typedef struct packed {
    logic             dbz;
    logic             ovf;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            overrun_q, overrun_d;

  logic            ev;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;
  entry_t          new_entry;

  // div_valid = 0 without error flags is passed through as a plain value.
  logic unused_div_valid;
  assign unused_div_valid = div_valid;

  assign full    = (count_q == FULL_CNT);
  assign m_valid = (count_q != '0);
  assign hold    = full;
  assign count   = count_q;
  assign overrun = overrun_q;
  assign m_dbz   = mem_q[rd_ptr_q].dbz;
  assign m_ovf   = mem_q[rd_ptr_q].ovf;
  assign m_data  = mem_q[rd_ptr_q].data;

  // The divider raises overflow as a level with no done pulse, so its rising edge is an event.
  assign ev   = div_done | (div_ovf & ~ovf_q);
  assign pop  = m_valid & m_ready;
  assign push = ev & (~full | pop);
  assign drop = ev & full & ~pop;

  always_comb begin
    new_entry = '0;
    if (div_dbz) begin
      new_entry.data = q_neg ? SAT_MIN : SAT_MAX;
      new_entry.dbz  = 1'b1;
    end else if (div_ovf) begin
      new_entry.data = q_neg ? SAT_MIN : SAT_MAX;
      new_entry.ovf  = 1'b1;
    end else begin
      new_entry.data = div_val;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = div_ovf;
    overrun_d = overrun_q;

    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: the storage array is reset with the control state so that an empty buffer
  // reads back as all zeros, not as stale entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_div_result_buf.sv
// Directed bench for div_result_buf: a table of single-result vectors plus hand-written
// sequences for overflow levels, full/overrun, push-pop on full, wrap and async reset.
module tb_div_result_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam logic [31:0] MAX_V = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_V = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             div_done, div_valid, div_dbz, div_ovf, q_neg;
  logic [WIDTH-1:0] div_val;
  logic             hold, m_valid, m_ready, m_dbz, m_ovf, overrun, clr_overrun;
  logic [WIDTH-1:0] m_data;
  logic [3:0]       count;

  int total  = 0;
  int passed = 0;

  div_result_buf #(.WIDTH(WIDTH), .FBITS(29), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .div_done(div_done), .div_valid(div_valid), .div_dbz(div_dbz), .div_ovf(div_ovf),
    .div_val(div_val), .q_neg(q_neg),
    .hold(hold), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_dbz(m_dbz), .m_ovf(m_ovf), .count(count),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        done, valid, dbz, ovf, neg;
    logic [31:0] val;
    logic [31:0] exp_data;
    logic        exp_dbz, exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    div_done = 1'b0; div_valid = 1'b0; div_dbz = 1'b0; div_ovf = 1'b0;
    q_neg = 1'b0; div_val = '0; m_ready = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic push_val(input logic [31:0] v);
    div_done = 1'b1; div_valid = 1'b1; div_val = v;
    tick();
    div_done = 1'b0; div_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"normal",      1, 1, 0, 0, 0, 32'h3000_0000, 32'h3000_0000, 0, 0};
    vecs[1] = '{"dbz_neg",     1, 0, 1, 0, 1, 32'h1234_0000, MIN_V,         1, 0};
    vecs[2] = '{"dbz_pos",     1, 0, 1, 0, 0, 32'h1234_0000, MAX_V,         1, 0};
    vecs[3] = '{"ovf_done",    1, 0, 0, 1, 1, 32'h0000_0055, MIN_V,         0, 1};
    vecs[4] = '{"dbz_over_ovf",1, 0, 1, 1, 0, 32'h0000_0066, MAX_V,         1, 0};
    vecs[5] = '{"invalid_pass",1, 0, 0, 0, 1, 32'h1234_5678, 32'h1234_5678, 0, 0};
    vecs[6] = '{"negative",    1, 1, 0, 0, 1, 32'hF000_0000, 32'hF000_0000, 0, 0};
    vecs[7] = '{"ovf_edge",    0, 0, 0, 1, 0, 32'h0000_0077, MAX_V,         0, 1};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_hold",    32'(hold),    32'd0);
    check("rst_count",   32'(count),   32'd0);
    check("rst_m_data",  m_data,       32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      div_done = vecs[i].done; div_valid = vecs[i].valid; div_dbz = vecs[i].dbz;
      div_ovf  = vecs[i].ovf;  q_neg     = vecs[i].neg;   div_val = vecs[i].val;
      tick();
      idle_inputs();
      check({vecs[i].name, "_valid"}, 32'(m_valid), 32'd1);
      check({vecs[i].name, "_data"},  m_data, vecs[i].exp_data);
      check({vecs[i].name, "_dbz"},   32'(m_dbz), 32'(vecs[i].exp_dbz));
      check({vecs[i].name, "_ovf"},   32'(m_ovf), 32'(vecs[i].exp_ovf));
      check({vecs[i].name, "_count"}, 32'(count), 32'd1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check({vecs[i].name, "_empty"}, 32'(m_valid), 32'd0);
    end

    // Overflow level held for 5 cycles yields a single entry.
    div_ovf = 1'b1; q_neg = 1'b0;
    repeat (5) tick();
    div_ovf = 1'b0;
    check("ovf_hold_count", 32'(count), 32'd1);
    check("ovf_hold_data",  m_data,     MAX_V);
    check("ovf_hold_flag",  32'(m_ovf), 32'd1);
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("ovf_hold_empty", 32'(count), 32'd0);

    // Fill, overrun, drain in order, then clear overrun.
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_hold_low", 32'(hold), 32'd0);
      push_val(32'h100 + 32'(i));
    end
    check("full_count",   32'(count),   32'd8);
    check("full_hold",    32'(hold),    32'd1);
    check("full_no_ovr",  32'(overrun), 32'd0);
    push_val(32'hDEAD);
    check("drop_count",   32'(count),   32'd8);
    check("drop_overrun", 32'(overrun), 32'd1);
    check("drop_head",    m_data,       32'h100);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", m_data, 32'h100 + 32'(i));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("drain_hold_low", 32'(hold), 32'd0);
    end
    check("drain_empty",  32'(m_valid), 32'd0);
    check("ovr_sticky",   32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_cleared",  32'(overrun), 32'd0);

    // Push and pop on a full FIFO; the new entry comes out last, after the wrap.
    for (int i = 0; i < DEPTH; i++) push_val(32'h200 + 32'(i));
    m_ready = 1'b1;
    push_val(32'h2FF);
    m_ready = 1'b0;
    check("pp_full_count", 32'(count),   32'd8);
    check("pp_full_hold",  32'(hold),    32'd1);
    check("pp_no_overrun", 32'(overrun), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      check("pp_order", m_data, (i == DEPTH) ? 32'h2FF : 32'h200 + 32'(i));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    check("pp_empty", 32'(count), 32'd0);

    // Asynchronous reset in the middle of a drain with five entries queued.
    for (int i = 0; i < 6; i++) push_val(32'h300 + 32'(i));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_head",  m_data,     32'h301);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_count", 32'(count),   32'd0);
    check("arst_data",  m_data,       32'd0);
    check("arst_hold",  32'(hold),    32'd0);
    check("arst_flags", 32'({m_dbz, m_ovf}), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_val(32'h0ABC_0000);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_data",  m_data,     32'h0ABC_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
